// File: rtl/evm_pkg.sv
// Purpose: shared widths and types for the EVM result path.
// Contents: default widths (CAND_W_DEF, VOTE_W_DEF, N_CAND_DEF),
//           cand_num_t, vote_cnt_t, winner_t.
package evm_pkg;

    localparam int unsigned CAND_W_DEF = 4;
    localparam int unsigned VOTE_W_DEF = 4;
    localparam int unsigned N_CAND_DEF = 3;

    typedef logic [CAND_W_DEF-1:0] cand_num_t;
    typedef logic [VOTE_W_DEF-1:0] vote_cnt_t;

    typedef struct packed {
        cand_num_t cand;
        vote_cnt_t votes;
    } winner_t;

endpackage : evm_pkg

// File: rtl/winner_cmp2.sv
// Purpose: two-input compare/select cell. It keeps the incumbent unless the
//          challenger's count is strictly greater.
// Ports:   inc_cand_i/inc_votes_i  incumbent (higher-priority) slot
//          chl_cand_i/chl_votes_i  challenger slot
//          win_cand_c/win_votes_c  combinational selection, taken from one slot only
module winner_cmp2
    import evm_pkg::*;
#(
    parameter int unsigned CAND_W = CAND_W_DEF,
    parameter int unsigned VOTE_W = VOTE_W_DEF
) (
    input  logic [CAND_W-1:0] inc_cand_i,
    input  logic [VOTE_W-1:0] inc_votes_i,
    input  logic [CAND_W-1:0] chl_cand_i,
    input  logic [VOTE_W-1:0] chl_votes_i,
    output logic [CAND_W-1:0] win_cand_c,
    output logic [VOTE_W-1:0] win_votes_c
);

    logic take_chl;

    // Strict compare: equal counts keep the incumbent.
    assign take_chl    = (chl_votes_i > inc_votes_i);
    assign win_cand_c  = take_chl ? chl_cand_i  : inc_cand_i;
    assign win_votes_c = take_chl ? chl_votes_i : inc_votes_i;

endmodule : winner_cmp2

// File: rtl/winner_logic.sv
// Purpose: election-result stage. Picks the slot with the highest vote count;
//          ties go to the highest-index slot. Registered, 1-cycle latency.
// Ports:   clk, rst_n (async active-low)
//          in_valid, candidate_numbers[N_CAND], vote_counts[N_CAND]
//          out_valid, winner_candidate, winner_vote_count
//          tie (only with WINNER_TIE_DETECT_EN defined)
// Config:  WINNER_TIE_DETECT_EN adds the registered tie flag.
module winner_logic
    import evm_pkg::*;
#(
    parameter int unsigned N_CAND = N_CAND_DEF,
    parameter int unsigned CAND_W = CAND_W_DEF,
    parameter int unsigned VOTE_W = VOTE_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [N_CAND-1:0][CAND_W-1:0]  candidate_numbers,
    input  logic [N_CAND-1:0][VOTE_W-1:0]  vote_counts,
    output logic                           out_valid,
    output logic [CAND_W-1:0]              winner_candidate,
`ifdef WINNER_TIE_DETECT_EN
    output logic [VOTE_W-1:0]              winner_vote_count,
    output logic                           tie
`else
    output logic [VOTE_W-1:0]              winner_vote_count
`endif
);

    // chain_*[i] is the best among slots N_CAND-1 down to i.
    logic [CAND_W-1:0] chain_cand  [N_CAND];
    logic [VOTE_W-1:0] chain_votes [N_CAND];

    assign chain_cand[N_CAND-1]  = candidate_numbers[N_CAND-1];
    assign chain_votes[N_CAND-1] = vote_counts[N_CAND-1];

    // Scan downward: the higher-index result is always the incumbent.
    for (genvar i = 0; i < int'(N_CAND) - 1; i++) begin : g_chain
        winner_cmp2 #(
            .CAND_W (CAND_W),
            .VOTE_W (VOTE_W)
        ) u_cmp (
            .inc_cand_i  (chain_cand[i+1]),
            .inc_votes_i (chain_votes[i+1]),
            .chl_cand_i  (candidate_numbers[i]),
            .chl_votes_i (vote_counts[i]),
            .win_cand_c  (chain_cand[i]),
            .win_votes_c (chain_votes[i])
        );
    end

    logic              out_valid_q, out_valid_d;
    logic [CAND_W-1:0] winner_candidate_q, winner_candidate_d;
    logic [VOTE_W-1:0] winner_vote_count_q, winner_vote_count_d;

    // Capture on in_valid, otherwise hold.
    always_comb begin
        out_valid_d         = in_valid;
        winner_candidate_d  = winner_candidate_q;
        winner_vote_count_d = winner_vote_count_q;
        if (in_valid) begin
            winner_candidate_d  = chain_cand[0];
            winner_vote_count_d = chain_votes[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q         <= 1'b0;
            winner_candidate_q  <= '0;
            winner_vote_count_q <= '0;
        end else begin
            out_valid_q         <= out_valid_d;
            winner_candidate_q  <= winner_candidate_d;
            winner_vote_count_q <= winner_vote_count_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign winner_candidate  = winner_candidate_q;
    assign winner_vote_count = winner_vote_count_q;

`ifdef WINNER_TIE_DETECT_EN
    localparam int unsigned CNT_W = $clog2(N_CAND + 1);

    logic [CNT_W-1:0] n_max;
    logic             tie_q, tie_d;

    // Tie when more than one slot holds the winning count.
    always_comb begin
        n_max = '0;
        for (int unsigned k = 0; k < N_CAND; k++) begin
            if (vote_counts[k] == chain_votes[0]) begin
                n_max = n_max + CNT_W'(1);
            end
        end
        tie_d = tie_q;
        if (in_valid) begin
            tie_d = (n_max > CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tie_q <= 1'b0;
        end else begin
            tie_q <= tie_d;
        end
    end

    assign tie = tie_q;
`endif

endmodule : winner_logic

// File: tb/tb_winner_logic.sv
// Self-checking bench for winner_logic: directed cases followed by random
// vectors, compared against a max-then-highest-index reference model.
module tb_winner_logic;

    localparam int unsigned N  = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned VW = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic [N-1:0][CW-1:0]   cand;
    logic [N-1:0][VW-1:0]   votes;
    logic                   out_valid;
    logic [CW-1:0]          w_cand;
    logic [VW-1:0]          w_votes;
`ifdef WINNER_TIE_DETECT_EN
    logic                   tie;
`endif

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    logic          exp_valid;
    logic [CW-1:0] exp_cand;
    logic [VW-1:0] exp_votes;
    logic          exp_tie;

    winner_logic #(
        .N_CAND (N),
        .CAND_W (CW),
        .VOTE_W (VW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .candidate_numbers (cand),
        .vote_counts       (votes),
        .out_valid         (out_valid),
        .winner_candidate  (w_cand),
`ifdef WINNER_TIE_DETECT_EN
        .winner_vote_count (w_votes),
        .tie               (tie)
`else
        .winner_vote_count (w_votes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".cand"},      32'(w_cand),    32'(exp_cand));
        check({tag, ".votes"},     32'(w_votes),   32'(exp_votes));
`ifdef WINNER_TIE_DETECT_EN
        check({tag, ".tie"},       32'(tie),       32'(exp_tie));
`endif
    endtask

    // Reference: find the maximum count, then the highest slot holding it.
    task automatic model(input logic v, input logic [N-1:0][CW-1:0] c,
                         input logic [N-1:0][VW-1:0] t);
        int unsigned mx;
        int unsigned win;
        int unsigned hits;
        exp_valid = v;
        if (v) begin
            mx = 0;
            for (int i = 0; i < int'(N); i++) if (int'(t[i]) > int'(mx)) mx = t[i];
            win  = 0;
            hits = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (int'(t[i]) == int'(mx)) begin
                    win = i;
                    hits++;
                end
            end
            exp_cand  = c[win];
            exp_votes = t[win];
            exp_tie   = (hits > 1);
        end
    endtask

    // Called at posedge+1: drive inputs, advance one edge, compare.
    task automatic step(input string tag, input logic v,
                        input logic [N-1:0][CW-1:0] c, input logic [N-1:0][VW-1:0] t);
        in_valid = v;
        cand     = c;
        votes    = t;
        @(posedge clk);
        #1;
        model(v, c, t);
        check_all(tag);
    endtask

    initial begin
        logic [N-1:0][CW-1:0] rc;
        logic [N-1:0][VW-1:0] rv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cand      = '0;
        votes     = '0;
        exp_valid = 1'b0;
        exp_cand  = '0;
        exp_votes = '0;
        exp_tie   = 1'b0;

        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases, slots listed {2,1,0}
        step("c1_top",    1'b1, {4'd2, 4'd1, 4'd0}, {4'd3, 4'd2, 4'd1});
        step("c2_slot0",  1'b1, {4'd0, 4'd1, 4'd2}, {4'd1, 4'd2, 4'd3});
        step("c3_tie2",   1'b1, {4'd0, 4'd1, 4'd2}, {4'd3, 4'd3, 4'd2});
        step("c4_zero",   1'b1, {4'd0, 4'd1, 4'd2}, {4'd0, 4'd0, 4'd0});
        step("tie_low",   1'b1, {4'd7, 4'd8, 4'd9}, {4'd2, 4'd5, 4'd5});
        step("max_cnt",   1'b1, {4'd5, 4'd5, 4'd6}, {4'd14, 4'd15, 4'd15});
        step("c5_mid",    1'b1, {4'd0, 4'd1, 4'd2}, {4'd1, 4'd4, 4'd2});
        step("c5_hold",   1'b0, {4'd9, 4'd9, 4'd9}, {4'd15, 4'd0, 4'd0});
        step("c5_hold2",  1'b0, {4'd3, 4'd4, 4'd5}, {4'd0, 4'd0, 4'd9});

        // Asynchronous reset mid-cycle, held across an edge with in_valid=1
        #2;
        rst_n     = 1'b0;
        exp_valid = 1'b0;
        exp_cand  = '0;
        exp_votes = '0;
        exp_tie   = 1'b0;
        #1;
        check_all("c5_async_rst");
        in_valid = 1'b1;
        cand     = {4'd2, 4'd1, 4'd0};
        votes    = {4'd3, 4'd2, 4'd1};
        @(posedge clk);
        #1;
        check_all("rst_wins");
        rst_n = 1'b1;

        // Back-to-back captures
        step("c6_b2b_a", 1'b1, {4'd2, 4'd1, 4'd0}, {4'd3, 4'd2, 4'd1});
        step("c6_b2b_b", 1'b1, {4'd0, 4'd1, 4'd2}, {4'd1, 4'd2, 4'd3});

        // Random vectors; small count ranges make ties common
        for (int n = 0; n < 60; n++) begin
            for (int s = 0; s < int'(N); s++) begin
                rc[s] = CW'($urandom_range(0, 15));
                rv[s] = ($urandom_range(0, 1) == 0) ? VW'($urandom_range(0, 2))
                                                     : VW'($urandom_range(0, 15));
            end
            step("rand", ($urandom_range(0, 3) != 0), rc, rv);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_winner_logic
